ktc16_cpu: RTL and testbench
============================

// Module: ktc16_cpu
// PURPOSE
//  Multicycle 32-bit-datapath CPU core executing 16-bit KTC16 instructions.
//  Talks to one unified instruction/data memory: a single 32-bit word port.
//  The memory has combinational read (rd valid in the same cycle as addr) and a
//  synchronous write on the rising clk edge when memwrite=1.
//  Top of the KTC16 subsystem; the only master on the memory port.
// PARAMETERS
//  RESET_PC  32'h0  fetch address after reset
// PORTS
//  clk       in   1   single system clock; all state changes on rising edge
//  reset     in   1   synchronous, active-low; sampled on rising clk edge
//  rd        in   32  memory read data for the current addr (combinational)
//  memwrite  out  1   memory write strobe, 1 cycle per store
//  addr      out  32  byte address, word-aligned (addr[1:0]=0)
//  wd        out  32  memory write data
// BEHAVIOUR
//  Reset (reset=0 at an edge), taking priority over any operation in progress:
//   - pc=RESET_PC, state=FETCH, ir=0, r1..r7=0
//   - memwrite=0, addr=RESET_PC, wd=0
//  Registers: r0..r7, 32-bit each; r0 reads 0 and writes to it are dropped.
//  State machine: FETCH -> EXEC -> FETCH (all non-memory instructions, 2 cycles).
//   lw and sw go FETCH -> EXEC -> MEM -> FETCH (3 cycles).
//  FETCH: addr={pc[31:2],2'b00}. ir latched = pc[1] ? rd[31:16] : rd[15:0]
//   (little-endian halfwords).
//  EXEC: decode/execute; register write-back, pc update; lw/sw latch ea.
//   Default next pc is pc+2. Branch/jump offsets are relative to pc+2.
//  MEM: addr={ea[31:2],2'b00}.
//   sw: memwrite=1, wd=R[d] for this cycle only.
//   lw: R[d]=rd at the end of the cycle.
//  Outside MEM: memwrite=0 and addr tracks pc.
//  Encoding: op=ir[15:11], d=ir[10:8], s=ir[7:5], f/i5=ir[4:0], i8=ir[7:0].
//  op 00000, R-type, function f:
//   0 mov d=s; 1 add; 2 sub; 3 and; 4 or; 5 xor
//   6 sll; 7 srl; 8 sra (shift amount = s[4:0])
//   9 slt (signed); 10 sltu (unsigned) -> d = 1 or 0
//   11 jalr: d=pc+2, pc=s[31:1]<<1
//   other f values: nop
//   Binary ops compute d = d OP s.
//  op 00001 addi: d=d+sext(i8).   op 00010 li: d=sext(i8).
//  op 00011 lsi: d={d[23:0],i8}.
//  op 00100 lw: ea=s+zext(i5)<<2.   op 00101 sw: ea=s+zext(i5)<<2, stores d.
//  op 00110 beq / 00111 bne / 01000 blt (signed) / 01001 bltu: compare d vs s;
//   if taken, pc=pc+2+(sext(i5)<<1).
//  op 01010 jal: d=pc+2, pc=pc+2+(sext(i8)<<1).
//  Undefined opcodes execute as nop (pc+2).
//  Arithmetic: 32-bit wraps modulo 2^32, no flags, no traps.
//  Misaligned ea: the low 2 bits are ignored.
//  Source registers are read before write-back, so d=s uses old values.
// TESTING
//  Store: li r1,7; li r2,84; sw r1,0(r2)
//   -> exactly one memwrite pulse, addr=84, wd=7, in the 7th cycle after reset release.
//  Reset: hold reset=0 for 2 cycles mid-program
//   -> next cycle addr=0, memwrite=0; program restarts from 0.
//  ALU: li r1,-3; li r2,5; add r1,r2; sw r1,20(r0)
//   -> write addr 80, wd 2.
//   Also check: slt gives 1, sltu gives 0.
//  Branch loop: li r1,0; li r3,7; loop: addi r1,1; bne r1,r3,loop; sw r1,21(r0)
//   -> single write, addr 84, wd 7.
//  Load/lsi: lsi builds 32'h12345678; sw then lw round-trips the value
//   -> later sw shows wd=32'h12345678.
//   lw uses the 3-cycle path.
//  jal/jalr: call and return
//   -> link register = call pc+2; execution resumes at the return point.
//   Writes to r0 leave r0=0.

Source files
------------

// File: rtl/ktc16_cpu.sv
// KTC16 multicycle CPU: 16-bit instructions, 32-bit datapath, one unified word-wide memory port.
// Fetch/execute takes 2 cycles; lw/sw add a memory cycle.
module ktc16_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd,
    output logic        memwrite,
    output logic [31:0] addr,
    output logic [31:0] wd
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd1;
    localparam logic [4:0] OP_LI   = 5'd2;
    localparam logic [4:0] OP_LSI  = 5'd3;
    localparam logic [4:0] OP_LW   = 5'd4;
    localparam logic [4:0] OP_SW   = 5'd5;
    localparam logic [4:0] OP_BEQ  = 5'd6;
    localparam logic [4:0] OP_BNE  = 5'd7;
    localparam logic [4:0] OP_BLT  = 5'd8;
    localparam logic [4:0] OP_BLTU = 5'd9;
    localparam logic [4:0] OP_JAL  = 5'd10;

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [15:0] ir, ir_n;
    logic [31:0] regs [8];
    logic        memwrite_n;
    logic [31:0] addr_n, wd_n;

    logic [4:0]  op, f;
    logic [2:0]  di, si;
    logic [7:0]  i8;
    logic [31:0] dv, sv, pc2, imm8, off8, off5;
    logic [29:0] ea_word;
    logic        we;
    logic [31:0] wval;

    assign op = ir[15:11];
    assign di = ir[10:8];
    assign si = ir[7:5];
    assign f  = ir[4:0];
    assign i8 = ir[7:0];

    // regs[0] is reset and never written, so it always reads zero
    assign dv   = regs[di];
    assign sv   = regs[si];
    assign pc2  = pc + 32'd2;
    assign imm8 = {{24{i8[7]}}, i8};
    assign off8 = {{23{i8[7]}}, i8, 1'b0};
    assign off5 = {{26{f[4]}}, f, 1'b0};
    // zext(i5)<<2 never touches the low two bits, so only the word part needs adding
    assign ea_word = sv[31:2] + 30'(f);

    // next-state, write-back and next memory-port values
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        we         = 1'b0;
        wval       = 32'd0;
        memwrite_n = 1'b0;
        addr_n     = {pc[31:2], 2'b00};
        wd_n       = wd;
        case (state)
            FETCH: begin
                ir_n    = pc[1] ? rd[31:16] : rd[15:0];
                state_n = EXEC;
            end
            EXEC: begin
                state_n = FETCH;
                pc_n    = pc2;
                case (op)
                    OP_R: begin
                        we = 1'b1;
                        case (f)
                            5'd0:  wval = sv;
                            5'd1:  wval = dv + sv;
                            5'd2:  wval = dv - sv;
                            5'd3:  wval = dv & sv;
                            5'd4:  wval = dv | sv;
                            5'd5:  wval = dv ^ sv;
                            5'd6:  wval = dv << sv[4:0];
                            5'd7:  wval = dv >> sv[4:0];
                            5'd8:  wval = 32'($signed(dv) >>> sv[4:0]);
                            5'd9:  wval = {31'd0, $signed(dv) < $signed(sv)};
                            5'd10: wval = {31'd0, dv < sv};
                            5'd11: begin
                                wval = pc2;
                                pc_n = {sv[31:1], 1'b0};
                            end
                            default: we = 1'b0;
                        endcase
                    end
                    OP_ADDI: begin
                        we   = 1'b1;
                        wval = dv + imm8;
                    end
                    OP_LI: begin
                        we   = 1'b1;
                        wval = imm8;
                    end
                    OP_LSI: begin
                        we   = 1'b1;
                        wval = {dv[23:0], i8};
                    end
                    OP_LW: state_n = MEM;
                    OP_SW: begin
                        state_n    = MEM;
                        memwrite_n = 1'b1;
                        wd_n       = dv;
                    end
                    OP_BEQ:  if (dv == sv) pc_n = pc2 + off5;
                    OP_BNE:  if (dv != sv) pc_n = pc2 + off5;
                    OP_BLT:  if ($signed(dv) < $signed(sv)) pc_n = pc2 + off5;
                    OP_BLTU: if (dv < sv) pc_n = pc2 + off5;
                    OP_JAL: begin
                        we   = 1'b1;
                        wval = pc2;
                        pc_n = pc2 + off8;
                    end
                    default: ;
                endcase
                addr_n = (state_n == MEM) ? {ea_word, 2'b00} : {pc_n[31:2], 2'b00};
            end
            MEM: begin
                state_n = FETCH;
                if (op == OP_LW) begin
                    we   = 1'b1;
                    wval = rd;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // state, architectural registers and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= 16'd0;
            memwrite <= 1'b0;
            addr     <= RESET_PC;
            wd       <= 32'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            memwrite <= memwrite_n;
            addr     <= addr_n;
            wd       <= wd_n;
            if (we && di != 3'd0) regs[di] <= wval;
        end
    end

endmodule

// File: tb/tb_ktc16_cpu.sv
// Bench for ktc16_cpu: unified memory model, directed programs, ALU vector table and
// random programs checked against an instruction-level reference interpreter.
module tb_ktc16_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rd;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wd;

    ktc16_cpu dut (
        .clk(clk), .reset(reset), .rd(rd),
        .memwrite(memwrite), .addr(addr), .wd(wd)
    );

    always #5 clk = ~clk;

    localparam int LI = 2, ADDI = 1, LSI = 3, LW = 4, SW = 5, JAL = 10;
    localparam logic [15:0] HALT = {5'd10, 3'd0, 8'hFF};

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        string       name;
        int          f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic        load_req = 1'b0;

    assign rd = mem[addr[9:2]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (memwrite) begin
            mem[addr[9:2]] <= wd;
        end
    end

    // write log, cycles counted from reset release (cycle 1 = first fetch)
    int  cyc;
    wr_t wq[$];
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0;
            wq.delete();
        end else begin
            cyc++;
            if (memwrite) wq.push_back('{cyc, addr, wd});
        end
    end

    wr_t eq[$];
    int  errors = 0;
    int  checks = 0;
    int  asm_pc;

    function automatic logic [15:0] ei8(int op, int d, int i8);
        return {5'(op), 3'(d), 8'(i8)};
    endfunction
    function automatic logic [15:0] ei5(int op, int d, int s, int i5);
        return {5'(op), 3'(d), 3'(s), 5'(i5)};
    endfunction
    function automatic logic [15:0] er(int f, int d, int s);
        return {5'd0, 3'(d), 3'(s), 5'(f)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_w(string tag, int idx, logic [31:0] a, logic [31:0] d);
        if (idx < wq.size()) begin
            chk($sformatf("%s w%0d addr", tag, idx), wq[idx].a, a);
            chk($sformatf("%s w%0d data", tag, idx), wq[idx].d, d);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s w%0d missing: got %0d writes", tag, idx, wq.size());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
        asm_pc = 0;
    endtask

    task automatic emit(logic [15:0] h);
        if (asm_pc[1]) img[asm_pc >> 2][31:16] = h;
        else           img[asm_pc >> 2][15:0]  = h;
        asm_pc += 2;
    endtask

    task automatic load_const(int r, logic [31:0] v);
        emit(ei8(LI, r, int'(v[31:24])));
        emit(ei8(LSI, r, int'(v[23:16])));
        emit(ei8(LSI, r, int'(v[15:8])));
        emit(ei8(LSI, r, int'(v[7:0])));
    endtask

    task automatic start();
        reset = 1'b0;
        load_req = 1'b1;
        tick();
        tick();
        load_req = 1'b0;
        reset = 1'b1;
    endtask

    // instruction-level reference: executes img, producing the expected store log with cycle stamps
    task automatic iss_run();
        logic [31:0] r [8];
        logic [31:0] m [256];
        logic [31:0] pc, nxt, a, b, res, ea;
        logic [15:0] h;
        logic [7:0]  i8;
        logic [4:0]  i5;
        int          c, op, d, s, f, cost, sh;
        bit          wr, taken;
        eq.delete();
        for (int i = 0; i < 8; i++) r[i] = 32'd0;
        for (int i = 0; i < 256; i++) m[i] = img[i];
        pc = 32'd0;
        c  = 0;
        for (int step = 0; step < 2000; step++) begin
            h = pc[1] ? m[pc[9:2]][31:16] : m[pc[9:2]][15:0];
            if (h == HALT) break;
            op = int'(h[15:11]); d = int'(h[10:8]); s = int'(h[7:5]); f = int'(h[4:0]);
            i8 = h[7:0]; i5 = h[4:0];
            a = r[d]; b = r[s]; sh = int'(b[4:0]);
            wr = 1'b0; res = 32'd0; nxt = pc + 32'd2; cost = 2; taken = 1'b0;
            ea = b + 32'(int'(i5) * 4);
            case (op)
                0: begin
                    wr = 1'b1;
                    case (f)
                        0: res = b;
                        1: res = a + b;
                        2: res = a - b;
                        3: res = a & b;
                        4: res = a | b;
                        5: res = a ^ b;
                        6: res = a << sh;
                        7: res = a >> sh;
                        8: begin
                            res = a >> sh;
                            if (a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
                        end
                        9:  res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
                        10: res = (a < b) ? 32'd1 : 32'd0;
                        11: begin
                            res = pc + 32'd2;
                            nxt = b & ~32'd1;
                        end
                        default: wr = 1'b0;
                    endcase
                end
                1: begin wr = 1'b1; res = a + 32'(int'($signed(i8))); end
                2: begin wr = 1'b1; res = 32'(int'($signed(i8))); end
                3: begin wr = 1'b1; res = (a << 8) | {24'd0, i8}; end
                4: begin wr = 1'b1; res = m[ea[9:2]]; cost = 3; end
                5: begin
                    cost = 3;
                    eq.push_back('{c + 3, ea & ~32'd3, a});
                    m[ea[9:2]] = a;
                end
                6: taken = (a == b);
                7: taken = (a != b);
                8: taken = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
                9: taken = (a < b);
                10: begin
                    wr = 1'b1;
                    res = pc + 32'd2;
                    nxt = pc + 32'(2 + 2 * int'($signed(i8)));
                end
                default: ;
            endcase
            if (taken) nxt = pc + 32'(2 + 2 * int'($signed(i5)));
            if (wr && d != 0) r[d] = res;
            pc = nxt;
            c += cost;
        end
    endtask

    task automatic compare(string tag);
        int n;
        chk({tag, " nwrites"}, 32'(wq.size()), 32'(eq.size()));
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s w%0d cycle", tag, i), 32'(wq[i].cyc), 32'(eq[i].cyc));
            chk($sformatf("%s w%0d addr", tag, i), wq[i].a, eq[i].a);
            chk($sformatf("%s w%0d data", tag, i), wq[i].d, eq[i].d);
        end
    endtask

    task automatic run_prog(string tag, int ncyc);
        iss_run();
        start();
        repeat (ncyc) tick();
        compare(tag);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{"mov",  0,  32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{"add",  1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{"sub",  2,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
            '{"and",  3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
            '{"or",   4,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
            '{"xor",  5,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
            '{"sll",  6,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
            '{"sll5", 6,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
            '{"srl",  7,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
            '{"sra",  8,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
            '{"slt",  9,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001},
            '{"sltu", 10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000},
            '{"nop",  12, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005}
        };

        // store timing and reset values
        clear_img();
        emit(ei8(LI, 1, 7));
        emit(ei8(LI, 2, 84));
        emit(ei5(SW, 1, 2, 0));
        emit(HALT);
        reset = 1'b0;
        load_req = 1'b1;
        tick();
        chk("reset addr", addr, 32'd0);
        chk("reset memwrite", 32'(memwrite), 32'd0);
        chk("reset wd", wd, 32'd0);
        tick();
        load_req = 1'b0;
        reset = 1'b1;
        repeat (20) tick();
        chk("store nwrites", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("store cycle", 32'(wq[0].cyc), 32'd7);
        expect_w("store", 0, 32'd84, 32'd7);
        iss_run();
        compare("store iss");

        // reset during the sw EXEC cycle suppresses the store; reset clears wd afterwards
        start();
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("midreset memwrite", 32'(memwrite), 32'd0);
        chk("midreset addr", addr, 32'd0);
        tick();
        reset = 1'b1;
        repeat (7) tick();
        chk("restart nwrites", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("restart cycle", 32'(wq[0].cyc), 32'd7);
        reset = 1'b0;
        tick();
        chk("reset2 wd", wd, 32'd0);
        chk("reset2 addr", addr, 32'd0);
        chk("reset2 memwrite", 32'(memwrite), 32'd0);
        tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("rerun nwrites", 32'(wq.size()), 32'd1);
        expect_w("rerun", 0, 32'd84, 32'd7);

        // ALU, slt/sltu on negative operand
        clear_img();
        emit(ei8(LI, 1, -3));
        emit(ei8(LI, 2, 5));
        emit(er(1, 1, 2));
        emit(ei5(SW, 1, 0, 20));
        emit(ei8(LI, 3, -3));
        emit(er(9, 3, 2));
        emit(ei5(SW, 3, 0, 21));
        emit(ei8(LI, 4, -3));
        emit(er(10, 4, 2));
        emit(ei5(SW, 4, 0, 22));
        emit(HALT);
        run_prog("alu", 60);
        expect_w("alu", 0, 32'd80, 32'd2);
        expect_w("alu", 1, 32'd84, 32'd1);
        expect_w("alu", 2, 32'd88, 32'd0);

        // backward branch loop
        clear_img();
        emit(ei8(LI, 1, 0));
        emit(ei8(LI, 3, 7));
        emit(ei8(ADDI, 1, 1));
        emit(ei5(7, 1, 3, -2));
        emit(ei5(SW, 1, 0, 21));
        emit(HALT);
        run_prog("loop", 80);
        chk("loop nwrites", 32'(wq.size()), 32'd1);
        expect_w("loop", 0, 32'd84, 32'd7);

        // lsi build, sw/lw round trip
        clear_img();
        emit(ei8(LI, 1, 8'h12));
        emit(ei8(LSI, 1, 8'h34));
        emit(ei8(LSI, 1, 8'h56));
        emit(ei8(LSI, 1, 8'h78));
        emit(ei5(SW, 1, 0, 24));
        emit(ei5(LW, 5, 0, 24));
        emit(ei5(SW, 5, 0, 25));
        emit(HALT);
        run_prog("lw", 40);
        expect_w("lw", 0, 32'd96, 32'h1234_5678);
        expect_w("lw", 1, 32'd100, 32'h1234_5678);
        if (wq.size() > 1) chk("lw second store cycle", 32'(wq[1].cyc), 32'd17);

        // call/return via jal/jalr, r0 stays zero
        clear_img();
        emit(ei8(LI, 2, 9));
        emit(ei8(JAL, 6, 4));
        emit(ei5(SW, 2, 0, 26));
        emit(ei5(SW, 6, 0, 27));
        emit(ei5(SW, 0, 0, 28));
        emit(HALT);
        emit(ei8(ADDI, 2, 1));
        emit(ei8(LI, 0, 5));
        emit(er(11, 0, 6));
        emit(HALT);
        run_prog("jal", 60);
        expect_w("jal", 0, 32'd104, 32'd10);
        expect_w("jal", 1, 32'd108, 32'd4);
        expect_w("jal", 2, 32'd112, 32'd0);

        // R-type vector table
        foreach (vecs[k]) begin
            clear_img();
            load_const(1, vecs[k].a);
            load_const(2, vecs[k].b);
            emit(er(vecs[k].f, 1, 2));
            emit(ei5(SW, 1, 0, 30));
            emit(HALT);
            start();
            repeat (40) tick();
            chk({vecs[k].name, " nwrites"}, 32'(wq.size()), 32'd1);
            expect_w(vecs[k].name, 0, 32'd120, vecs[k].exp);
        end

        // random programs against the reference interpreter
        for (int p = 0; p < 25; p++) begin
            clear_img();
            for (int w = 128; w < 256; w++) img[w] = $urandom;
            emit(ei8(LI, 7, 2));
            emit(ei8(LSI, 7, 0));
            for (int n = 0; n < 30; n++) begin
                int k, fn;
                k = int'($urandom_range(0, 9));
                case (k)
                    0: emit(ei8(LI, int'($urandom_range(0, 6)), int'($urandom_range(0, 255))));
                    1: emit(ei8(LSI, int'($urandom_range(0, 6)), int'($urandom_range(0, 255))));
                    2: emit(ei8(ADDI, int'($urandom_range(0, 6)), int'($urandom_range(0, 255))));
                    3, 4, 5: begin
                        fn = int'($urandom_range(0, 12));
                        if (fn == 11) fn = 15;
                        emit(er(fn, int'($urandom_range(0, 6)), int'($urandom_range(0, 7))));
                    end
                    6: emit(ei5(SW, int'($urandom_range(0, 7)), 7, int'($urandom_range(0, 31))));
                    7: emit(ei5(LW, int'($urandom_range(0, 6)), 7, int'($urandom_range(0, 31))));
                    8: emit(ei5(int'($urandom_range(6, 9)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 3))));
                    default: emit(ei8(JAL, int'($urandom_range(0, 6)), int'($urandom_range(0, 3))));
                endcase
            end
            for (int r = 1; r <= 6; r++) emit(ei5(SW, r, 7, 25 + r));
            repeat (4) emit(HALT);
            run_prog($sformatf("rand%0d", p), 220);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
